load_store_unit: RTL and testbench

- Initiator side of the CPU data-memory interface.
- Accepts load/store requests from the datapath over a valid/ready handshake.
- Drives the byte-addressed, little-endian data memory port: address, write data, write enable. That memory reads combinationally and writes on posedge.
- Adds byte loads (zero-extended) and byte stores, done as read-modify-write because the memory only writes whole 4-byte words.

---
 rtl/lsu_pkg.sv | 15 +
 rtl/lsu_byte_merge.sv | 20 ++
 rtl/load_store_unit.sv | 121 ++++++++++++
 tb/tb_load_store_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int BYTE_W     = 8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } lsu_state_t;

endpackage

// File: rtl/lsu_byte_merge.sv
// Byte-lane helpers: zero-extended byte extract for loads and the
// read-modify-write merge for byte stores.
module lsu_byte_merge
   import lsu_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic [DATA_W-1:0] rd,
   input  logic [BYTE_W-1:0] wd,
   output logic [DATA_W-1:0] byte_ext,
   output logic [DATA_W-1:0] merged
);

   always_comb begin
      byte_ext               = '0;
      byte_ext[BYTE_W-1:0]   = rd[BYTE_W-1:0];
      merged                 = {rd[DATA_W-1:BYTE_W], wd};
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit driving a combinational-read, posedge-write word memory.
// Optional misaligned word check enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic              req_byte,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] mem_A,
   output logic [DATA_W-1:0] mem_WD,
   output logic              mem_MemWrite,
   input  logic [DATA_W-1:0] mem_out
);

   lsu_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q;
   logic [BYTE_W-1:0] wbyte_q;
   logic              write_q;
   logic              byte_q;
   logic [DATA_W-1:0] wd_q;
   logic [DATA_W-1:0] rdata_q;
   logic [DATA_W-1:0] byte_ext;
   logic [DATA_W-1:0] merged;
   logic              misalign;

`ifdef LSU_ALIGN_CHECK_EN
   logic err_q;
   assign misalign = !req_byte && (req_addr[1:0] != 2'b00);
   assign rsp_err  = (state_q == RESP) && err_q;
`else
   assign misalign = 1'b0;
   assign rsp_err  = 1'b0;
`endif

   lsu_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .rd       (mem_out),
      .wd       (wbyte_q),
      .byte_ext (byte_ext),
      .merged   (merged)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (misalign)                     state_d = RESP;
               else if (req_write && !req_byte)  state_d = WRITE;
               else                              state_d = READ;
            end
         end
         READ:    state_d = write_q ? WRITE : RESP;
         WRITE:   state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // mem_A/mem_WD are registers loaded on the edge entering READ/WRITE,
   // so they naturally hold their last value in every other state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wbyte_q <= '0;
         write_q <= 1'b0;
         byte_q  <= 1'b0;
         wd_q    <= '0;
         rdata_q <= '0;
`ifdef LSU_ALIGN_CHECK_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  write_q <= req_write;
                  byte_q  <= req_byte;
                  wbyte_q <= req_wdata[BYTE_W-1:0];
`ifdef LSU_ALIGN_CHECK_EN
                  err_q   <= misalign;
`endif
                  if (misalign) begin
                     rdata_q <= '0;
                  end else begin
                     addr_q <= req_addr;
                     if (req_write && !req_byte)
                        wd_q <= req_wdata;
                  end
               end
            end
            READ: begin
               if (write_q) wd_q    <= merged;
               else         rdata_q <= byte_q ? byte_ext : mem_out;
            end
            WRITE:   rdata_q <= '0;
            default: ;
         endcase
      end
   end

   assign req_ready    = (state_q == IDLE);
   assign rsp_valid    = (state_q == RESP);
   assign rsp_rdata    = rdata_q;
   assign mem_A        = addr_q;
   assign mem_WD       = wd_q;
   assign mem_MemWrite = (state_q == WRITE) && rst_n;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-array memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_byte = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_MemWrite;
   logic [31:0] mem_out;

   int unsigned tests_run = 0;
   int unsigned tests_failed = 0;

   logic [7:0] mem  [256];
   logic [7:0] refm [256];
   logic       mem_init = 1'b1;

`ifdef LSU_ALIGN_CHECK_EN
   localparam bit ALIGN_CHK = 1'b1;
`else
   localparam bit ALIGN_CHK = 1'b0;
`endif

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_byte     (req_byte),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_A        (mem_A),
      .mem_WD       (mem_WD),
      .mem_MemWrite (mem_MemWrite),
      .mem_out      (mem_out)
   );

   always #5 clk = ~clk;

   // Little-endian byte memory: combinational read, posedge word write.
   always_comb begin
      mem_out = {mem[mem_A[7:0] + 8'd3], mem[mem_A[7:0] + 8'd2],
                 mem[mem_A[7:0] + 8'd1], mem[mem_A[7:0]]};
   end

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
      end else if (mem_MemWrite) begin
         for (int i = 0; i < 4; i++) mem[mem_A[7:0] + 8'(i)] <= mem_WD[8*i +: 8];
      end
   end

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      logic [7:0] b;
      b = a[7:0];
      return {refm[b + 8'd3], refm[b + 8'd2], refm[b + 8'd1], refm[b]};
   endfunction

   // One transaction; compares latency, data, error and memory traffic with the model.
   task automatic do_req(input logic w, input logic b, input logic [31:0] a,
                         input logic [31:0] wd, input string name,
                         output logic [31:0] got_rd);
      logic        misal, exp_err, got_err, got;
      int unsigned exp_lat, lat, writes, exp_writes, waits;
      logic [31:0] exp_rd, exp_wd, seen_wd, seen_a;
      misal      = ALIGN_CHK && !b && (a[1:0] != 2'b00);
      exp_err    = misal;
      exp_lat    = misal ? 1 : ((w && b) ? 3 : 2);
      exp_rd     = (misal || w) ? 32'h0 : (b ? {24'h0, refm[a[7:0]]} : ref_word(a));
      exp_writes = (w && !misal) ? 1 : 0;
      exp_wd     = '0;
      if (w && !misal) begin
         if (b) refm[a[7:0]] = wd[7:0];
         else for (int i = 0; i < 4; i++) refm[a[7:0] + 8'(i)] = wd[8*i +: 8];
         exp_wd = ref_word(a);
      end
      waits = 0;
      while (!req_ready && waits < 10) begin
         @(negedge clk);
         waits++;
      end
      if (!req_ready) begin
         tests_run++;
         tests_failed++;
         $display("FAIL %s ready_timeout: req_ready=%0b required 1", name, req_ready);
      end
      req_valid = 1'b1; req_write = w; req_byte = b; req_addr = a; req_wdata = wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
      lat = 0; writes = 0; got = 1'b0; got_rd = '0; got_err = 1'b0;
      seen_wd = '0; seen_a = '0;
      for (int k = 1; k <= 8; k++) begin
         if (!got) begin
            @(negedge clk);
            if (mem_MemWrite) begin
               writes++;
               seen_wd = mem_WD;
               seen_a  = mem_A;
            end
            if (rsp_valid) begin
               got = 1'b1; lat = k; got_rd = rsp_rdata; got_err = rsp_err;
            end
         end
      end
      tests_run++;
      if (lat !== exp_lat) begin
         tests_failed++;
         $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
      end
      tests_run++;
      if (got_rd !== exp_rd) begin
         tests_failed++;
         $display("FAIL %s rdata: got %h required %h", name, got_rd, exp_rd);
      end
      tests_run++;
      if (got_err !== exp_err) begin
         tests_failed++;
         $display("FAIL %s err: got %b required %b", name, got_err, exp_err);
      end
      tests_run++;
      if (writes !== exp_writes) begin
         tests_failed++;
         $display("FAIL %s write_pulses: got %0d required %0d", name, writes, exp_writes);
      end
      if (exp_writes == 1) begin
         tests_run++;
         if (seen_wd !== exp_wd || seen_a !== a) begin
            tests_failed++;
            $display("FAIL %s write_data: got A=%h WD=%h required A=%h WD=%h",
                     name, seen_a, seen_wd, a, exp_wd);
         end
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if ({req_ready, rsp_valid, rsp_err, mem_MemWrite} !== 4'b1000 ||
          rsp_rdata !== 32'h0 || mem_A !== 32'h0 || mem_WD !== 32'h0) begin
         tests_failed++;
         $display("FAIL reset_state: got ready=%b valid=%b err=%b we=%b rd=%h A=%h WD=%h required 1 0 0 0 0 0 0",
                  req_ready, rsp_valid, rsp_err, mem_MemWrite, rsp_rdata, mem_A, mem_WD);
      end
   endtask

   task automatic test_word_load();
      logic [31:0] rd;
      do_req(1'b0, 1'b0, 32'd16, 32'h0, "word_load16", rd);
      tests_run++;
      if (rd !== 32'h13121110) begin
         tests_failed++;
         $display("FAIL word_load16_const: got %h required 13121110", rd);
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (rsp_rdata !== 32'h13121110) begin
         tests_failed++;
         $display("FAIL rdata_hold: got %h required 13121110", rsp_rdata);
      end
   endtask

   task automatic test_byte_load();
      logic [31:0] rd;
      do_req(1'b0, 1'b1, 32'd20, 32'h0, "byte_load20", rd);
      tests_run++;
      if (rd !== 32'h00000014) begin
         tests_failed++;
         $display("FAIL byte_load20_const: got %h required 00000014", rd);
      end
   endtask

   task automatic test_byte_store();
      logic [31:0] rd;
      do_req(1'b1, 1'b1, 32'd16, 32'h000000AB, "byte_store16", rd);
      do_req(1'b0, 1'b0, 32'd16, 32'h0, "load_after_bstore", rd);
      tests_run++;
      if (rd !== 32'h131211AB) begin
         tests_failed++;
         $display("FAIL byte_store16_const: got %h required 131211ab", rd);
      end
   endtask

   task automatic test_word_store();
      logic [31:0] rd;
      do_req(1'b1, 1'b0, 32'd32, 32'hDEADBEEF, "word_store32", rd);
      do_req(1'b0, 1'b0, 32'd32, 32'h0, "load32", rd);
      tests_run++;
      if (rd !== 32'hDEADBEEF) begin
         tests_failed++;
         $display("FAIL word_store32_const: got %h required deadbeef", rd);
      end
      do_req(1'b0, 1'b0, 32'd36, 32'h0, "load36", rd);
      tests_run++;
      if (rd !== 32'h27262524) begin
         tests_failed++;
         $display("FAIL load36_const: got %h required 27262524", rd);
      end
   endtask

   task automatic test_unaligned();
      logic [31:0] rd;
      do_req(1'b0, 1'b0, 32'd17, 32'h0, "word_load17", rd);
      tests_run++;
      if (rd !== (ALIGN_CHK ? 32'h0 : 32'h14131211)) begin
         tests_failed++;
         $display("FAIL word_load17_const: got %h required %h", rd,
                  ALIGN_CHK ? 32'h0 : 32'h14131211);
      end
   endtask

   task automatic test_reset_mid_write();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_byte = 1'b1;
      req_addr = 32'd40; req_wdata = 32'h00000055;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      tests_run++;
      if (mem_MemWrite !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_write_pre: mem_MemWrite=%b required 1", mem_MemWrite);
      end
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (mem_MemWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_write_gate: mem_MemWrite=%b required 0", mem_MemWrite);
      end
      @(negedge clk);
      tests_run++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || mem_A !== 32'h0 ||
          mem_WD !== 32'h0 || rsp_rdata !== 32'h0 || mem_MemWrite !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_write_state: valid=%b ready=%b A=%h WD=%h rd=%h we=%b required 0 1 0 0 0 0",
                  rsp_valid, req_ready, mem_A, mem_WD, rsp_rdata, mem_MemWrite);
      end
      tests_run++;
      if ({mem[43], mem[42], mem[41], mem[40]} !== ref_word(32'd40)) begin
         tests_failed++;
         $display("FAIL rst_write_mem: got %h required %h",
                  {mem[43], mem[42], mem[41], mem[40]}, ref_word(32'd40));
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         tests_run++;
         if (rsp_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_write_no_rsp: rsp_valid=%b required 0", rsp_valid);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, a;
      logic        w, b;
      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
         b = 1'($urandom);
         a = 32'($urandom_range(0, 252));
         if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
         do_req(w, b, a, $urandom, "random", rd);
      end
   endtask

   task automatic test_back_to_back();
      int unsigned hs, rsps;
      logic [31:0] exp;
      exp = ref_word(32'd64);
      hs = 0; rsps = 0;
      while (!req_ready) @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_addr = 32'd64;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) @(negedge clk);
         if (req_ready) hs++;
         if (rsp_valid) begin
            rsps++;
            tests_run++;
            if (rsp_rdata !== exp || req_ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL b2b_rsp: rdata=%h ready=%b required %h 0", rsp_rdata, req_ready, exp);
            end
         end
      end
      req_valid = 1'b0;
      tests_run++;
      if (hs !== 4 || rsps !== 4) begin
         tests_failed++;
         $display("FAIL b2b_count: handshakes=%0d responses=%0d required 4 4", hs, rsps);
      end
   endtask

   task automatic test_memory_image();
      int unsigned bad;
      bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== refm[i]) bad++;
      tests_run++;
      if (bad != 0) begin
         tests_failed++;
         $display("FAIL memory_image: %0d bytes differ, required 0", bad);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) refm[i] = 8'(i);
      repeat (3) @(posedge clk);
      #1 mem_init = 1'b0;
      @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_word_load();
      test_byte_load();
      test_byte_store();
      test_word_store();
      test_unaligned();
      test_reset_mid_write();
      test_random();
      test_back_to_back();
      repeat (3) @(negedge clk);
      test_memory_image();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
